// File: rtl/line_memory_pkg.sv
// rtl/line_memory_pkg.sv - shared widths, state encoding and default latency for line_memory
// Contents: LINE_W (line width in bits), OFFSET_W (byte offset bits within a line),
// DEFAULT_LATENCY (BUSY cycles per request), state_t (controller state encoding).
package line_memory_pkg;

  localparam int LINE_W          = 256;
  localparam int OFFSET_W        = 5;
  localparam int DEFAULT_LATENCY = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/line_memory_array.sv
// rtl/line_memory_array.sv - DEPTH x 256-bit single-port line store, sync write, async read
// Ports:
//   clk_i    clock, write happens on rising edge
//   we_i     write enable
//   addr_i   line index, shared by read and write
//   wdata_i  line to write
//   rdata_o  line currently addressed (combinational)
// Contents are never reset; power-up values are whatever the simulator provides.
module line_memory_array
  import line_memory_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [LINE_W-1:0]     wdata_i,
  output logic [LINE_W-1:0]     rdata_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [LINE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/line_memory.sv
// rtl/line_memory.sv - fixed-latency 256-bit line memory for cache refill and write-back
// Ports:
//   clk_i     clock, rising edge
//   rst_i     asynchronous active-low reset
//   enable_i  request valid (sampled only in IDLE)
//   write_i   1 = line write, 0 = line read
//   addr_i    byte address; line index = addr_i[DEPTH_LOG2+4:5]
//   data_i    write line data
//   ack_o     one-cycle completion pulse
//   data_o    last read line; updated only when a read completes
module line_memory
  import line_memory_pkg::*;
#(
  parameter int LATENCY    = DEFAULT_LATENCY,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);

  localparam logic [7:0] LAST_CNT = 8'(LATENCY - 1);

  state_t                state_q;
  state_t                state_d;
  logic [7:0]            cnt_q;
  logic                  req_write_q;
  logic [DEPTH_LOG2-1:0] req_idx_q;
  logic [LINE_W-1:0]     req_data_q;
  logic [LINE_W-1:0]     rd_data;
  logic                  accept;
  logic                  finish;

  // Upper address bits alias and the byte offset is irrelevant for whole-line access.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:DEPTH_LOG2+OFFSET_W], addr_i[OFFSET_W-1:0]};

  assign accept = (state_q == ST_IDLE) && enable_i;
  // The BUSY->ACK edge is where the memory access actually takes effect.
  assign finish = (state_q == ST_BUSY) && (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable_i) state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == LAST_CNT) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= 8'd0;
    end else if (accept) begin
      cnt_q <= 8'd0;
    end else if (state_q == ST_BUSY) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // Request registers only load on acceptance, so input churn during BUSY/ACK is harmless.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      req_write_q <= 1'b0;
      req_idx_q   <= '0;
      req_data_q  <= '0;
    end else if (accept) begin
      req_write_q <= write_i;
      req_idx_q   <= addr_i[DEPTH_LOG2+OFFSET_W-1:OFFSET_W];
      req_data_q  <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_o <= '0;
    end else if (finish && !req_write_q) begin
      data_o <= rd_data;
    end
  end

  // Derived from state so reset clears it immediately.
  assign ack_o = (state_q == ST_ACK);

  line_memory_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (finish && req_write_q),
    .addr_i (req_idx_q),
    .wdata_i(req_data_q),
    .rdata_o(rd_data)
  );

endmodule

// File: tb/tb_line_memory.sv
// tb/tb_line_memory.sv - self-checking bench for line_memory (LATENCY=10 and LATENCY=1 instances)
module tb_line_memory;

  localparam int LAT = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0, wr = 1'b0;
  logic [31:0]  addr = '0;
  logic [255:0] din = '0;
  logic         ack;
  logic [255:0] dout;
  logic         en1 = 1'b0, wr1 = 1'b0;
  logic [31:0]  addr1 = '0;
  logic [255:0] din1 = '0;
  logic         ack1;
  logic [255:0] dout1;

  int checks = 0;
  int passes = 0;

  logic [255:0] model [int];
  logic [255:0] exp_dout = '0;
  logic [31:0]  known [$];

  always #5 clk = ~clk;

  line_memory #(.LATENCY(LAT), .DEPTH_LOG2(9)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .write_i(wr),
    .addr_i(addr), .data_i(din), .ack_o(ack), .data_o(dout)
  );

  line_memory #(.LATENCY(1), .DEPTH_LOG2(9)) dut1 (
    .clk_i(clk), .rst_i(rst), .enable_i(en1), .write_i(wr1),
    .addr_i(addr1), .data_i(din1), .ack_o(ack1), .data_o(dout1)
  );

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 5) % 32'd512);
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Drives one request in cycle 0, then watches LAT+6 cycles, recording acks.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [255:0] d,
                         input bit churn, output int ack_cyc, output int n_ack,
                         output logic [255:0] d_at_ack);
    ack_cyc = -1; n_ack = 0; d_at_ack = '0;
    @(negedge clk);
    en = 1'b1; wr = w; addr = a; din = d;
    for (int c = 1; c <= LAT + 6; c++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        n_ack++;
        if (ack_cyc < 0) begin ack_cyc = c; d_at_ack = dout; end
      end
      if (churn && n_ack == 0) begin
        en = 1'($urandom); wr = 1'($urandom); addr = $urandom; din = rand256();
      end else begin
        en = 1'b0;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (ack !== 1'b0 || dout !== '0) $display("FAIL reset_hold ack=%b dout=%h want 0/0", ack, dout); else passes++;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ack !== 1'b0 || dout !== '0) $display("FAIL reset_state ack=%b dout=%h want 0/0", ack, dout); else passes++;
    checks++; if (ack1 !== 1'b0 || dout1 !== '0) $display("FAIL reset_state1 ack=%b dout=%h want 0/0", ack1, dout1); else passes++;
  endtask

  task automatic test_read_basic();
    int ac, na; logic [255:0] d;
    logic [255:0] pat = {32{8'hA5}};
    run_txn(1'b1, 32'h60, pat, 1'b0, ac, na, d);
    model[line_of(32'h60)] = pat;
    checks++; if (ac != LAT + 1 || na != 1 || d !== exp_dout) $display("FAIL preload_write cyc=%0d n=%0d dout=%h want %0d/1/%h", ac, na, d, LAT + 1, exp_dout); else passes++;
    run_txn(1'b0, 32'h60, rand256(), 1'b0, ac, na, d);
    exp_dout = pat;
    checks++; if (ac != LAT + 1 || na != 1) $display("FAIL read_latency cyc=%0d n=%0d want %0d/1", ac, na, LAT + 1); else passes++;
    checks++; if (d !== pat) $display("FAIL read_data got %h want %h", d, pat); else passes++;
  endtask

  task automatic test_write_read();
    int ac, na; logic [255:0] d;
    logic [255:0] pat = {8{32'h12345678}};
    run_txn(1'b1, 32'h200, pat, 1'b0, ac, na, d);
    model[line_of(32'h200)] = pat;
    checks++; if (d !== exp_dout || ac != LAT + 1) $display("FAIL write_keeps_dout got %h cyc=%0d want %h/%0d", d, ac, exp_dout, LAT + 1); else passes++;
    run_txn(1'b0, 32'h200, '0, 1'b0, ac, na, d);
    exp_dout = pat;
    checks++; if (d !== pat || na != 1) $display("FAIL raw_data got %h n=%0d want %h/1", d, na, pat); else passes++;
  endtask

  task automatic test_back_to_back();
    int ac, na; logic [255:0] d;
    int ack_c [$]; logic [255:0] ack_d [$];
    logic [255:0] x = rand256();
    logic [255:0] y = rand256();
    run_txn(1'b1, 32'h800, y, 1'b0, ac, na, d);
    model[line_of(32'h800)] = y;
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = 32'h400; din = x;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        ack_c.push_back(c); ack_d.push_back(dout);
        if (ack_c.size() == 1) begin wr = 1'b0; addr = 32'h800; din = rand256(); end
        else en = 1'b0;
      end
    end
    en = 1'b0;
    model[line_of(32'h400)] = x;
    checks++;
    if (ack_c.size() != 2) $display("FAIL b2b_ack_count got %0d want 2", ack_c.size());
    else if (ack_c[0] != 11 || ack_c[1] != 23) $display("FAIL b2b_ack_cycles got %0d,%0d want 11,23", ack_c[0], ack_c[1]);
    else if (ack_d[0] !== exp_dout || ack_d[1] !== y) $display("FAIL b2b_data got %h,%h want %h,%h", ack_d[0], ack_d[1], exp_dout, y);
    else passes++;
    exp_dout = y;
    run_txn(1'b0, 32'h400, '0, 1'b0, ac, na, d);
    exp_dout = x;
    checks++; if (d !== x) $display("FAIL b2b_writeback got %h want %h", d, x); else passes++;
  endtask

  task automatic test_churn();
    int ac, na; logic [255:0] d;
    logic [255:0] v = rand256();
    run_txn(1'b1, 32'h1E0, v, 1'b1, ac, na, d);
    model[line_of(32'h1E0)] = v;
    checks++; if (ac != LAT + 1 || na != 1 || d !== exp_dout) $display("FAIL churn_write cyc=%0d n=%0d dout=%h want %0d/1/%h", ac, na, d, LAT + 1, exp_dout); else passes++;
    run_txn(1'b0, 32'h1E0, '0, 1'b1, ac, na, d);
    exp_dout = v;
    checks++; if (ac != LAT + 1 || na != 1 || d !== v) $display("FAIL churn_read cyc=%0d n=%0d got %h want %0d/1/%h", ac, na, d, LAT + 1, v); else passes++;
  endtask

  task automatic test_reset_mid_write();
    int ac, na, seen; logic [255:0] d;
    logic [255:0] p = rand256();
    run_txn(1'b1, 32'h40, p, 1'b0, ac, na, d);
    model[line_of(32'h40)] = p;
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = 32'h40; din = ~p;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      en = 1'b0;
    end
    rst = 1'b0;
    #1;
    exp_dout = '0;
    checks++; if (ack !== 1'b0 || dout !== '0) $display("FAIL reset_async ack=%b dout=%h want 0/0", ack, dout); else passes++;
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < LAT + 5; c++) begin
      @(negedge clk);
      if (ack === 1'b1) seen++;
    end
    checks++; if (seen != 0) $display("FAIL reset_abort_ack got %0d acks want 0", seen); else passes++;
    run_txn(1'b0, 32'h40, '0, 1'b0, ac, na, d);
    exp_dout = p;
    checks++; if (d !== p) $display("FAIL reset_no_commit got %h want %h", d, p); else passes++;
  endtask

  task automatic test_random();
    int ac, na; logic [255:0] d, v;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) begin
      if (known.size() == 0 || $urandom_range(1, 0) == 1) begin
        a = $urandom; v = rand256();
        run_txn(1'b1, a, v, i[0], ac, na, d);
        checks++; if (ac != LAT + 1 || na != 1 || d !== exp_dout) $display("FAIL rand_write%0d cyc=%0d n=%0d dout=%h want %0d/1/%h", i, ac, na, d, LAT + 1, exp_dout); else passes++;
        model[line_of(a)] = v;
        known.push_back(a);
      end else begin
        a = ($urandom & ~32'h3FE0) | (known[$urandom_range(known.size() - 1, 0)] & 32'h3FE0);
        v = model[line_of(a)];
        run_txn(1'b0, a, rand256(), i[0], ac, na, d);
        checks++; if (ac != LAT + 1 || na != 1 || d !== v) $display("FAIL rand_read%0d cyc=%0d n=%0d got %h want %0d/1/%h", i, ac, na, d, LAT + 1, v); else passes++;
        exp_dout = v;
      end
    end
  endtask

  task automatic test_alias_lat1();
    logic [255:0] r = rand256();
    int ac [2]; logic [255:0] dd [2];
    for (int t = 0; t < 2; t++) begin
      ac[t] = -1; dd[t] = '0;
      @(negedge clk);
      en1 = 1'b1; wr1 = (t == 0); addr1 = (t == 0) ? 32'h4020 : 32'h0020; din1 = (t == 0) ? r : '0;
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        en1 = 1'b0;
        if (ack1 === 1'b1 && ac[t] < 0) begin ac[t] = c; dd[t] = dout1; end
      end
    end
    checks++; if (ac[0] != 2 || ac[1] != 2) $display("FAIL lat1_ack_cycle got %0d,%0d want 2,2", ac[0], ac[1]); else passes++;
    checks++; if (dd[0] !== '0) $display("FAIL lat1_write_dout got %h want 0", dd[0]); else passes++;
    checks++; if (dd[1] !== r) $display("FAIL lat1_alias_data got %h want %h", dd[1], r); else passes++;
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_read();
    test_back_to_back();
    test_churn();
    test_reset_mid_write();
    test_random();
    test_alias_lat1();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/line_memory.md
LINE_MEMORY -- requirements
Module: line_memory

Interface
REQ-001 Parameter LATENCY, default 10, number of BUSY cycles between request acceptance and acknowledge; legal range 1..255.
REQ-002 Parameter DEPTH_LOG2, default 9, log2 of the number of 256-bit lines stored (512 lines, 16 KiB).
REQ-003 clk_i  input  1  clock; all state changes on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 enable_i  input  1  request valid from the cache miss controller.
REQ-006 write_i  input  1  1 = line write (write-back), 0 = line read (refill); sampled with enable_i.
REQ-007 addr_i  input  32  byte address; bits [4:0] ignored; line index = addr_i[DEPTH_LOG2+4:5].
REQ-008 data_i  input  256  write line data; sampled with enable_i.
REQ-009 ack_o  output  1  one-cycle completion pulse for the accepted request.
REQ-010 data_o  output  256  read line data; valid while ack_o=1 for a read.

Function
REQ-011 The block SHALL implement states IDLE, BUSY and ACK.
REQ-012 IDLE: enable_i=1 at a rising edge SHALL latch addr_i, write_i and data_i into request registers, clear the latency counter and enter BUSY.
REQ-013 IDLE: enable_i=0 SHALL keep the block in IDLE with no side effects.
REQ-014 BUSY: the counter SHALL increment each cycle; on the edge where counter = LATENCY-1 the state SHALL become ACK.
REQ-015 BUSY and ACK: enable_i, write_i, addr_i and data_i SHALL be ignored; only latched values are used.
REQ-016 Write request: the latched 256-bit data SHALL be committed to the latched line index on the BUSY->ACK edge.
REQ-017 Read request: data_o SHALL be loaded from the latched line index on the BUSY->ACK edge.
REQ-018 ack_o SHALL be 1 exactly in the ACK cycle and 0 otherwise, for both reads and writes.
REQ-019 ACK SHALL always return to IDLE on the next edge, regardless of enable_i.
REQ-020 Latency: enable_i=1 in IDLE cycle 0 SHALL produce ack_o=1 in cycle LATENCY+1.
REQ-021 Back-to-back: a new request presented in the cycle after ACK (write-back followed by refill) SHALL be accepted in that cycle.
REQ-022 A request held high through ACK SHALL NOT be re-accepted; the requester deasserts or changes it on the ack edge.
REQ-023 data_o SHALL hold its last read value until the next read completes; write completions SHALL NOT change data_o.
REQ-024 Read-after-write to the same line SHALL return the newly written data.
REQ-025 Address bits above DEPTH_LOG2+4 SHALL be ignored; addresses alias modulo DEPTH lines.

Reset
REQ-026 rst_i=0 SHALL immediately force state IDLE, counter 0, ack_o 0 and data_o 0.
REQ-027 Reset during BUSY SHALL abort the request; a pending write SHALL NOT be committed.
REQ-028 Array contents SHALL NOT be cleared by reset; initial contents are loaded by the testbench only.

Structure
REQ-029 A shared package SHALL hold LINE_W=256, OFFSET_W=5, the state encoding (IDLE=0, BUSY=1, ACK=2, 2-bit) and the default LATENCY.
REQ-030 The storage SHALL be a sub-module line_memory_array: DEPTH x 256-bit, single port, synchronous write, asynchronous read.
REQ-031 The counter SHALL be 8 bits wide.

Verification
REQ-032 Read: preload line 3 with 0xA5 pattern, enable_i=1, write_i=0, addr_i=0x60 in cycle 0 -> ack_o=1 only in cycle 11, data_o = pattern.
REQ-033 Write-then-read: write 0x1234...(256-bit) to addr 0x200, then read 0x200 -> second ack returns 0x1234..., first ack leaves data_o unchanged.
REQ-034 Write-back then refill: write addr 0x400 with enable_i held, switch to read addr 0x800 on the ack edge -> two acks at cycles 11 and 23, correct data for each, no third ack.
REQ-035 Input churn: change addr_i and data_i every cycle during BUSY -> only cycle-0 values used.
REQ-036 Reset mid-write: assert rst_i=0 in cycle 5 of a write to 0x40 -> ack_o never pulses, later read of 0x40 returns the pre-write contents.
REQ-037 Aliasing and LATENCY=1: with DEPTH_LOG2=9, write 0x4020 then read 0x0020 -> same data; ack_o in cycle 2 after acceptance.
